im_port_arb: RTL and testbench

IM_PORT_ARB -- requirements
Module: im_port_arb

---
 rtl/im_port_arb_pkg.sv | 22 ++
 rtl/im_rd_tag_pipe.sv | 29 ++
 rtl/im_port_arb.sv | 129 ++++++++++++
 tb/tb_im_port_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_port_arb_pkg.sv
// Shared definitions for the two-port image-memory arbiter: FSM encoding,
// default geometry and the read-tag record carried down the rvalid pipeline.
package im_port_arb_pkg;

  localparam int IM_AW_DEF     = 20;
  localparam int IM_DW_DEF     = 24;
  localparam int MAX_BURST_DEF = 256;
  localparam int RD_STAGES     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/im_rd_tag_pipe.sv
// Delays a {valid, port} read tag by STAGES cycles so rvalid lines up with
// the memory's read data on IM_Q.
module im_rd_tag_pipe
  import im_port_arb_pkg::*;
#(
  parameter int STAGES = RD_STAGES
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output logic    o_rvalid0,
  output logic    o_rvalid1
);

  rd_tag_t r_pipe [STAGES:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[1] <= i_tag;
      for (int i = 2; i <= STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_rvalid0 = r_pipe[STAGES].vld & ~r_pipe[STAGES].port;
  assign o_rvalid1 = r_pipe[STAGES].vld &  r_pipe[STAGES].port;

endmodule

// File: rtl/im_port_arb.sv
// Two-port image-memory arbiter: burst ownership with round-robin tie-break,
// forced release after MAX_BURST beats under contention, one-cycle turnaround.
module im_port_arb
  import im_port_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int AW        = IM_AW_DEF,
  parameter int DW        = IM_DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          last0,
  input  logic          last1,
  input  logic          wen0,
  input  logic          wen1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] IM_A,
  output logic [DW-1:0] IM_D,
  output logic          IM_WEN
);

  localparam int            CW        = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_M1  = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  arb_state_t    r_state;
  logic          r_last_owner;
  logic [CW-1:0] r_cnt;
  logic          r_gnt0, r_gnt1;
  logic [AW-1:0] r_im_a;
  logic [DW-1:0] r_im_d;
  logic          r_im_wen;

  logic    w_acc0, w_acc1;
  logic    w_own_port, w_own_req, w_own_last, w_oth_req, w_release;
  rd_tag_t w_rd_tag;

  assign w_acc0 = req0 & r_gnt0;
  assign w_acc1 = req1 & r_gnt1;

  // Owner-relative view so both OWN states share one release rule.
  assign w_own_port = (r_state == ST_OWN1);
  assign w_own_req  = w_own_port ? req1  : req0;
  assign w_own_last = w_own_port ? last1 : last0;
  assign w_oth_req  = w_own_port ? req0  : req1;
  // The counter holds beats already taken, so BURST_M1 means this beat is number MAX_BURST.
  assign w_release  = ~w_own_req | w_own_last | ((r_cnt >= BURST_M1) & w_oth_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req0 && (!req1 || r_last_owner)) begin
            r_state <= ST_OWN0;
            r_gnt0  <= 1'b1;
            r_cnt   <= '0;
          end else if (req1) begin
            r_state <= ST_OWN1;
            r_gnt1  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (w_release) begin
            r_state      <= ST_TURN;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_last_owner <= w_own_port;
          end else if (r_cnt != BURST_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_TURN: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im_a   <= '0;
      r_im_d   <= '0;
      r_im_wen <= 1'b1;
    end else if (w_acc0) begin
      r_im_a   <= addr0;
      r_im_d   <= wdata0;
      r_im_wen <= wen0;
    end else if (w_acc1) begin
      r_im_a   <= addr1;
      r_im_d   <= wdata1;
      r_im_wen <= wen1;
    end else begin
      r_im_wen <= 1'b1;
    end
  end

  assign w_rd_tag.vld  = (w_acc0 & wen0) | (w_acc1 & wen1);
  assign w_rd_tag.port = w_acc1;

  im_rd_tag_pipe #(.STAGES(RD_STAGES)) u_rd_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .i_tag    (w_rd_tag),
    .o_rvalid0(rvalid0),
    .o_rvalid1(rvalid1)
  );

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign IM_A   = r_im_a;
  assign IM_D   = r_im_d;
  assign IM_WEN = r_im_wen;

endmodule

// File: tb/tb_im_port_arb.sv
// Bench for im_port_arb: directed vector table, hand sequences for forced
// release and mid-burst reset, then random traffic against a cycle model.
module tb_im_port_arb;

  localparam int AW = 20;
  localparam int DW = 24;
  localparam int MB = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
  logic          wen0 = 1'b0, wen1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, IM_WEN;
  logic [AW-1:0] IM_A;
  logic [DW-1:0] IM_D;

  always #5 clk = ~clk;

  im_port_arb #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .wen0(wen0), .wen1(wen1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .IM_A(IM_A), .IM_D(IM_D), .IM_WEN(IM_WEN)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, how many beats this grant has taken,
  // and a list of pending read returns keyed by the cycle they are due.
  typedef struct { int due; int port; } rd_t;
  int            m_own, m_prev, m_beats, cyc;
  bit            m_turn, m_acc0, m_acc1, e_rv0, e_rv1;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          m_wen;
  rd_t           m_rd[$];

  task automatic model_reset();
    m_own = -1; m_prev = 1; m_beats = 0; m_turn = 0;
    m_acc0 = 0; m_acc1 = 0; e_rv0 = 0; e_rv1 = 0;
    m_a = '0; m_d = '0; m_wen = 1'b1;
    m_rd.delete();
  endtask

  task automatic model_step();
    int  p;
    bit  rq, lst, oth, rel;
    m_acc0 = req0 && (m_own == 0);
    m_acc1 = req1 && (m_own == 1);
    if (m_acc0) begin
      m_a = addr0; m_d = wdata0; m_wen = wen0;
      if (wen0) m_rd.push_back('{cyc + 2, 0});
    end else if (m_acc1) begin
      m_a = addr1; m_d = wdata1; m_wen = wen1;
      if (wen1) m_rd.push_back('{cyc + 2, 1});
    end else begin
      m_wen = 1'b1;
    end
    if (m_turn) begin
      m_turn = 0;
    end else if (m_own < 0) begin
      m_beats = 0;
      if (req0 && req1) m_own = (m_prev == 0) ? 1 : 0;
      else if (req0)    m_own = 0;
      else if (req1)    m_own = 1;
    end else begin
      p   = m_own;
      rq  = (p == 1) ? req1  : req0;
      lst = (p == 1) ? last1 : last0;
      oth = (p == 1) ? req0  : req1;
      if (!rq) rel = 1;
      else begin
        m_beats++;
        rel = lst || (m_beats >= MB && oth);
      end
      if (rel) begin
        m_own = -1; m_turn = 1; m_prev = p;
      end
    end
    cyc++;
    e_rv0 = 0; e_rv1 = 0;
    while (m_rd.size() > 0 && m_rd[0].due <= cyc) begin
      if (m_rd[0].due == cyc) begin
        if (m_rd[0].port == 1) e_rv1 = 1; else e_rv0 = 1;
      end
      void'(m_rd.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    chk1("m_gnt0", gnt0, m_own == 0);
    chk1("m_gnt1", gnt1, m_own == 1);
    chk1("m_wen", IM_WEN, m_wen);
    chkv("m_addr", 32'(IM_A), 32'(m_a));
    chkv("m_data", 32'(IM_D), 32'(m_d));
    chk1("m_rv0", rvalid0, e_rv0);
    chk1("m_rv1", rvalid1, e_rv1);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; last0 = 0; last1 = 0; wen0 = 0; wen1 = 0;
  endtask

  typedef struct {
    logic r0, l0, w0; logic [AW-1:0] a0;
    logic r1, l1, w1; logic [AW-1:0] a1;
    logic g0, g1, iwen; logic [AW-1:0] ia;
    logic rv0, rv1;
  } vec_t;

  vec_t           vt[$];
  logic [AW-1:0]  obs[$];
  logic [AW-1:0]  fr_exp[12];
  int             b0, b1;
  bit             started;

  initial begin
    // tie-break after reset, then port 1 after the turnaround
    vt.push_back(vec_t'{H,L,L,20'h10,    H,L,L,20'h20,    H,L,H,20'h0,     L,L});
    vt.push_back(vec_t'{H,H,L,20'h10,    H,L,L,20'h20,    L,L,L,20'h10,    L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,L,20'h20,    L,L,H,20'h10,    L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,L,20'h20,    L,H,H,20'h10,    L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,H,L,20'h20,    L,L,L,20'h20,    L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h20,    L,L});
    // four-beat write burst on port 0
    vt.push_back(vec_t'{H,L,L,20'h100,   L,L,L,20'h0,     H,L,H,20'h20,    L,L});
    vt.push_back(vec_t'{H,L,L,20'h100,   L,L,L,20'h0,     H,L,L,20'h100,   L,L});
    vt.push_back(vec_t'{H,L,L,20'h101,   L,L,L,20'h0,     H,L,L,20'h101,   L,L});
    vt.push_back(vec_t'{H,L,L,20'h102,   L,L,L,20'h0,     H,L,L,20'h102,   L,L});
    vt.push_back(vec_t'{H,H,L,20'h103,   L,L,L,20'h0,     L,L,L,20'h103,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h103,   L,L});
    // three reads on port 1, rvalid1 two cycles after each acceptance
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,H,20'h80000, L,H,H,20'h103,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,H,20'h80000, L,H,H,20'h80000, L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,H,20'h80001, L,H,H,20'h80001, L,H});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,H,H,20'h80002, L,L,H,20'h80002, L,H});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h80002, L,H});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h80002, L,L});
    // aborts on port 0 and port 1
    vt.push_back(vec_t'{H,L,L,20'h200,   L,L,L,20'h0,     H,L,H,20'h80002, L,L});
    vt.push_back(vec_t'{H,L,L,20'h200,   L,L,L,20'h0,     H,L,L,20'h200,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h200,   L,L,L,20'h0,     L,L,H,20'h200,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h200,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     H,L,L,20'h300,   L,H,H,20'h200,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h300,   L,L,H,20'h200,   L,L});
    vt.push_back(vec_t'{L,L,L,20'h0,     L,L,L,20'h0,     L,L,H,20'h200,   L,L});

    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_rv0", rvalid0, 1'b0);
    chk1("rst_rv1", rvalid1, 1'b0);
    chk1("rst_wen", IM_WEN, 1'b1);
    chkv("rst_addr", 32'(IM_A), 32'h0);
    chkv("rst_data", 32'(IM_D), 32'h0);
    reset = 0;

    foreach (vt[i]) begin
      req0 = vt[i].r0; last0 = vt[i].l0; wen0 = vt[i].w0; addr0 = vt[i].a0;
      req1 = vt[i].r1; last1 = vt[i].l1; wen1 = vt[i].w1; addr1 = vt[i].a1;
      wdata0 = {4'h0, vt[i].a0} ^ 24'h5A5A5A;
      wdata1 = {4'h0, vt[i].a1} ^ 24'hA5A5A5;
      tick();
      chk1($sformatf("v%0d_gnt0", i), gnt0, vt[i].g0);
      chk1($sformatf("v%0d_gnt1", i), gnt1, vt[i].g1);
      chk1($sformatf("v%0d_wen", i), IM_WEN, vt[i].iwen);
      chkv($sformatf("v%0d_addr", i), 32'(IM_A), 32'(vt[i].ia));
      chk1($sformatf("v%0d_rv0", i), rvalid0, vt[i].rv0);
      chk1($sformatf("v%0d_rv1", i), rvalid1, vt[i].rv1);
    end

    // forced release: 10-beat write on port 0, port 1 joins during beat 2
    b0 = 0; b1 = 0; started = 0;
    for (int c = 0; c < 60 && !(b0 == 10 && b1 == 2); c++) begin
      req0 = (b0 < 10); addr0 = 20'h400 + 20'(b0); last0 = (b0 == 9); wen0 = 0;
      wdata0 = 24'(b0);
      req1 = started && (b1 < 2); addr1 = 20'h500 + 20'(b1); last1 = (b1 == 1); wen1 = 0;
      wdata1 = 24'h100 + 24'(b1);
      tick();
      if (m_acc0) b0++;
      if (m_acc1) b1++;
      if (b0 >= 1) started = 1;
      if (IM_WEN === 1'b0) obs.push_back(IM_A);
    end
    idle_inputs();
    chk1("fr_complete", (b0 == 10) && (b1 == 2), 1'b1);
    for (int i = 0; i < 4; i++) fr_exp[i] = 20'h400 + 20'(i);
    fr_exp[4] = 20'h500;
    fr_exp[5] = 20'h501;
    for (int i = 6; i < 12; i++) fr_exp[i] = 20'h404 + 20'(i - 6);
    chkv("fr_beats", 32'(obs.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < obs.size()) chkv($sformatf("fr_order%0d", i), 32'(obs[i]), 32'(fr_exp[i]));
    repeat (3) tick();

    // reset in the middle of a port-1 read burst
    req1 = 1; wen1 = 1; last1 = 0; addr1 = 20'h7000;
    repeat (4) begin
      tick();
      addr1 = addr1 + 20'h1;
    end
    #3 reset = 1;
    #1;
    chk1("mr_gnt0", gnt0, 1'b0);
    chk1("mr_gnt1", gnt1, 1'b0);
    chk1("mr_rv0", rvalid0, 1'b0);
    chk1("mr_rv1", rvalid1, 1'b0);
    chk1("mr_wen", IM_WEN, 1'b1);
    chkv("mr_addr", 32'(IM_A), 32'h0);
    chkv("mr_data", 32'(IM_D), 32'h0);
    model_reset();
    idle_inputs();
    repeat (2) tick();
    reset = 0;
    repeat (5) begin
      tick();
      chk1("mr_norv0", rvalid0, 1'b0);
      chk1("mr_norv1", rvalid1, 1'b0);
    end

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (req0) begin if ($urandom_range(7) == 0) req0 = 0; end
      else if ($urandom_range(3) == 0) req0 = 1;
      if (req1) begin if ($urandom_range(7) == 0) req1 = 0; end
      else if ($urandom_range(3) == 0) req1 = 1;
      last0 = ($urandom_range(9) == 0);
      last1 = ($urandom_range(9) == 0);
      wen0 = ($urandom_range(1) == 1);
      wen1 = ($urandom_range(1) == 1);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
